// File: rtl/cell_bist_harness_if.sv
// Bundles the run-control, stimulus/response and result signals of
// cell_bist_harness.
//   slave  : harness side (takes start/mode/resp, drives stim/busy/done/signature)
//   master : controller/array side (the opposite directions)
// Optional macro CELL_BIST_COMPARE_EN adds exp_sig (to harness) and pass/fail
// (from harness).
interface cell_bist_harness_if #(
    parameter int IN_W   = 6,
    parameter int OUT_W  = 73,
    parameter int MISR_W = 16
);
    logic              start;
    logic              mode;
    logic [IN_W-1:0]   stim;
    logic [OUT_W-1:0]  resp;
    logic              busy;
    logic              done;
    logic [MISR_W-1:0] signature;
`ifdef CELL_BIST_COMPARE_EN
    logic [MISR_W-1:0] exp_sig;
    logic              pass;
    logic              fail;

    modport slave  (input  start, mode, resp, exp_sig,
                    output stim, busy, done, signature, pass, fail);
    modport master (output start, mode, resp, exp_sig,
                    input  stim, busy, done, signature, pass, fail);
`else
    modport slave  (input  start, mode, resp,
                    output stim, busy, done, signature);
    modport master (output start, mode, resp,
                    input  stim, busy, done, signature);
`endif
endinterface

// File: rtl/cell_bist_harness.sv
// Built-in self-test sequencer for a standard-cell test array.
// Steps an exhaustive-counter or Galois-LFSR pattern onto the array inputs,
// holds each pattern SETTLE_CYC clocks, then folds the array response into a
// MISR signature for one CAPTURE cycle. N_PAT patterns per run.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : cell_bist_harness_if.slave
//            start/mode in, resp in, stim out, busy/done out, signature out
// Optional macro CELL_BIST_COMPARE_EN: compares the final signature against
// bus.exp_sig and reports bus.pass / bus.fail until the next start.
module cell_bist_harness #(
    parameter int                IN_W       = 6,
    parameter int                OUT_W      = 73,
    parameter int                N_PAT      = 64,
    parameter int                SETTLE_CYC = 2,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = 16'h1021,
    parameter logic [IN_W-1:0]   LFSR_TAPS  = 6'h21
) (
    input  logic              clk,
    input  logic              rst_n,
    cell_bist_harness_if.slave bus
);

    localparam int PC_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int NCH  = (OUT_W + MISR_W - 1) / MISR_W;
    localparam logic [PC_W-1:0] PAT_LAST = PC_W'(N_PAT - 1);
    localparam logic [SC_W-1:0] SET_INIT = SC_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t            state, state_d;
    logic [IN_W-1:0]   stim_q, stim_d, stim_adv;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [MISR_W-1:0] sig_q, sig_d, sig_next, fold;
    logic [PC_W-1:0]   pat_cnt, pat_cnt_d;
    logic [SC_W-1:0]   set_cnt, set_cnt_d;
    logic [NCH*MISR_W-1:0] resp_ext;
`ifdef CELL_BIST_COMPARE_EN
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
`endif

    // Zero-extend the response to whole MISR_W chunks and XOR the chunks together.
    always_comb begin
        resp_ext = '0;
        resp_ext[OUT_W-1:0] = bus.resp;
        fold = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            fold = fold ^ resp_ext[i*MISR_W +: MISR_W];
        end
    end

    assign sig_next = {sig_q[MISR_W-2:0], 1'b0}
                    ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                    ^ fold;

    assign stim_adv = mode_q ? ({stim_q[IN_W-2:0], 1'b0} ^ (stim_q[IN_W-1] ? LFSR_TAPS : '0))
                             : stim_q + IN_W'(1);

    always_comb begin
        state_d   = state;
        stim_d    = stim_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = done_q;
        sig_d     = sig_q;
        pat_cnt_d = pat_cnt;
        set_cnt_d = set_cnt;
`ifdef CELL_BIST_COMPARE_EN
        pass_d    = pass_q;
        fail_d    = fail_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = SETTLE;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    sig_d     = '0;
                    pat_cnt_d = '0;
                    set_cnt_d = SET_INIT;
                    mode_d    = bus.mode;
                    stim_d    = bus.mode ? IN_W'(1) : '0;
`ifdef CELL_BIST_COMPARE_EN
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (set_cnt == '0) begin
                    state_d = CAPTURE;
                end else begin
                    set_cnt_d = set_cnt - SC_W'(1);
                end
            end
            CAPTURE: begin
                sig_d = sig_next;
                if (pat_cnt == PAT_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef CELL_BIST_COMPARE_EN
                    pass_d  = (sig_next == bus.exp_sig);
                    fail_d  = (sig_next != bus.exp_sig);
`endif
                end else begin
                    state_d   = SETTLE;
                    pat_cnt_d = pat_cnt + PC_W'(1);
                    set_cnt_d = SET_INIT;
                    stim_d    = stim_adv;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            stim_q  <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= '0;
            pat_cnt <= '0;
            set_cnt <= '0;
`ifdef CELL_BIST_COMPARE_EN
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            stim_q  <= stim_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
            pat_cnt <= pat_cnt_d;
            set_cnt <= set_cnt_d;
`ifdef CELL_BIST_COMPARE_EN
            pass_q  <= pass_d;
            fail_q  <= fail_d;
`endif
        end
    end

    assign bus.stim      = stim_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig_q;
`ifdef CELL_BIST_COMPARE_EN
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
`endif

endmodule
